axis_alex_ctrl: RTL and testbench
=================================

# axis_alex_ctrl

Serialiser and bus-ownership controller for the ALEX filter/attenuator boards sharing the four GPIO lines with the I2S codec interface. Accepts 16-bit control words on an AXI4-Stream slave, takes ownership of the shared pins by asserting `alex_flag`, and shifts the word out MSB-first with a generated serial clock and a load strobe. It then releases the pins back to I2S. It drives the `alex_flag` / `alex_data` inputs of the I2S pin-sharing block directly.

## Interface
- `CLK_DIV`, default 4: `aclk` cycles per serial-clock half period; legal range 1..65535.
- `GUARD`, default 2: `aclk` cycles with `alex_flag` high and all lines low, both before the first bit and after the strobe; legal range 1..255.
- `aclk`  in  1  system clock; all logic on rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `enable`  in  1  when low, no new word is accepted; a transfer in progress always completes.
- `s_axis_tdata`  in  32  [15:0] payload; [16] strobe select (0 = TX load on `alex_data[2]`, 1 = RX load on `alex_data[3]`); [31:17] ignored.
- `s_axis_tvalid`  in  1  word valid.
- `s_axis_tready`  out  1  registered; high only in IDLE with `enable` high.
- `alex_flag`  out  1  registered; high while ALEX owns the pins.
- `alex_data`  out  4  registered; [0] SCLK, [1] SDATA, [2] TX load, [3] RX load.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LEAD, SHIFT, STROBE, TRAIL.
- IDLE: `alex_flag`=0, `alex_data`=0. `s_axis_tready` = `enable`, registered. A handshake (`tvalid & tready`) latches payload and select, loads the bit counter with 15 and the divider with 0, and moves to LEAD.
- LEAD: `alex_flag`=1, lines low, for GUARD cycles, then SHIFT.
- SHIFT: per bit, SDATA = current shift-register MSB. SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles. On the SCLK high-to-low transition the register shifts left.
  - After bit 0's high phase, SCLK and SDATA go low and the state moves to STROBE.
- STROBE: the selected strobe line is high for CLK_DIV cycles, others low; then TRAIL.
- TRAIL: `alex_flag`=1, all lines low, for GUARD cycles, then IDLE. `alex_flag` falls on entry to IDLE.
- SDATA changes only while SCLK is low; it is stable across every SCLK rising edge.
- `tready` is deasserted from the cycle after the handshake until IDLE is re-entered. There is no buffering: one word is in flight at most.
- `enable` falling mid-transfer has no effect on the current transfer.
- `s_axis_tvalid` held high continuously gives back-to-back transfers separated by exactly one IDLE cycle with `alex_flag`=0. That cycle returns the pins to I2S.
- Reset at any point: on the next edge all outputs are 0, state is IDLE, the word is discarded, and `s_axis_tready` = 0 during reset.

## Timing
- Handshake at edge N: `alex_flag`=1 from edge N+1.
- SCLK first rises at N+1+GUARD+CLK_DIV.
- `alex_flag` high duration = 2·GUARD + 33·CLK_DIV cycles. With defaults this is 2·2 + 33·4 = 136.
- Handshake-to-next-`tready` = 2·GUARD + 33·CLK_DIV + 1 cycles.
- Counters: divider 16 bits, bit counter 4 bits, guard counter 8 bits. No wrap occurs within legal parameter ranges.
- Reset values: `s_axis_tready`=0, `alex_flag`=0, `alex_data`=4'b0000, `busy`=0.

## Test plan
- Reset, then `enable`=1, tdata=0x0000A5C3, one-beat tvalid, defaults.
  - Required: 16 SCLK rising edges carry SDATA 1010010111000011.
  - `alex_data[2]` is high for 4 cycles and `alex_data[3]` stays 0.
  - `alex_flag` is high for exactly 136 cycles, and `tready` returns 137 cycles after the handshake.
- tdata=0x0001FFFF → all 16 sampled bits are 1; strobe appears on `alex_data[3]` only; `alex_data[2]` stays 0.
- tvalid held high with three words (0x0000, 0x8001, 0x1FFFF):
  - three transfers, each separated by exactly one cycle of `alex_flag`=0;
  - no word is skipped or duplicated.
- `enable` low with tvalid high → `tready`=0 and no `alex_flag` activity for 100 cycles.
- `enable` dropped mid-SHIFT → the transfer completes, then `tready` stays low.
- `areset` pulsed for 1 cycle mid-SHIFT → all outputs 0 on the next edge.
  - The next word after reset transfers correctly from bit 15.
- CLK_DIV=1, GUARD=1: tdata=0x00005555 → SCLK toggles every cycle; `alex_flag` high for 35 cycles; SDATA is stable at every SCLK rise.

Source files
------------

// File: rtl/axis_alex_ctrl.sv
// axis_alex_ctrl: serialises 16-bit ALEX control words from an AXI4-Stream
// slave onto the GPIO lines shared with I2S. It owns the pins via alex_flag
// for the whole frame (guard, 16 bits, load strobe, guard).
module axis_alex_ctrl #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned GUARD   = 2
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        enable,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic        alex_flag,
   output logic [3:0]  alex_data,
   output logic        busy
);

   localparam int unsigned DIV_W  = 16;
   localparam int unsigned BIT_W  = 4;
   localparam int unsigned GRD_W  = 8;
   localparam int unsigned WORD_W = 16;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD - 1);
   localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(WORD_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD,
      ST_SHIFT,
      ST_STROBE,
      ST_TRAIL
   } state_t;

   state_t              state, state_nxt;
   logic [WORD_W-1:0]   shreg, shreg_nxt;
   logic                sel, sel_nxt;
   logic                phase, phase_nxt;   // 0 = SCLK low half, 1 = SCLK high half
   logic [DIV_W-1:0]    div_cnt, div_nxt;
   logic [BIT_W-1:0]    bit_cnt, bit_nxt;
   logic [GRD_W-1:0]    grd_cnt, grd_nxt;

   logic                tready_nxt;
   logic                flag_nxt;
   logic                busy_nxt;
   logic [3:0]          data_nxt;

   // Bits [31:17] of the stream word carry nothing for this block.
   logic                tdata_unused;
   assign tdata_unused = ^s_axis_tdata[31:17];

   // Next-state, counter and output decode; outputs are derived from the
   // next state so the registered pins line up with the state register.
   always_comb begin
      state_nxt  = state;
      shreg_nxt  = shreg;
      sel_nxt    = sel;
      phase_nxt  = phase;
      div_nxt    = div_cnt;
      bit_nxt    = bit_cnt;
      grd_nxt    = grd_cnt;

      case (state)
         ST_IDLE: begin
            if (s_axis_tvalid && s_axis_tready) begin
               state_nxt = ST_LEAD;
               shreg_nxt = s_axis_tdata[WORD_W-1:0];
               sel_nxt   = s_axis_tdata[16];
               bit_nxt   = BIT_TOP;
               div_nxt   = '0;
               grd_nxt   = '0;
               phase_nxt = 1'b0;
            end
         end
         ST_LEAD: begin
            if (grd_cnt == GRD_LAST) begin
               state_nxt = ST_SHIFT;
               phase_nxt = 1'b0;
               div_nxt   = '0;
            end else begin
               grd_nxt = grd_cnt + GRD_W'(1);
            end
         end
         ST_SHIFT: begin
            if (div_cnt != DIV_LAST) begin
               div_nxt = div_cnt + DIV_W'(1);
            end else begin
               div_nxt = '0;
               if (!phase) begin
                  phase_nxt = 1'b1;
               end else if (bit_cnt == '0) begin
                  state_nxt = ST_STROBE;
                  phase_nxt = 1'b0;
               end else begin
                  // SCLK falls here, so the next bit is presented in the low half
                  phase_nxt = 1'b0;
                  shreg_nxt = {shreg[WORD_W-2:0], 1'b0};
                  bit_nxt   = bit_cnt - BIT_W'(1);
               end
            end
         end
         ST_STROBE: begin
            if (div_cnt != DIV_LAST) begin
               div_nxt = div_cnt + DIV_W'(1);
            end else begin
               state_nxt = ST_TRAIL;
               div_nxt   = '0;
               grd_nxt   = '0;
            end
         end
         ST_TRAIL: begin
            if (grd_cnt == GRD_LAST) begin
               state_nxt = ST_IDLE;
            end else begin
               grd_nxt = grd_cnt + GRD_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      flag_nxt   = (state_nxt != ST_IDLE);
      busy_nxt   = (state_nxt != ST_IDLE);
      tready_nxt = (state_nxt == ST_IDLE) && enable;
      data_nxt   = {(state_nxt == ST_STROBE) &&  sel_nxt,
                    (state_nxt == ST_STROBE) && !sel_nxt,
                    (state_nxt == ST_SHIFT)  &&  shreg_nxt[WORD_W-1],
                    (state_nxt == ST_SHIFT)  &&  phase_nxt};
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state         <= ST_IDLE;
         shreg         <= '0;
         sel           <= 1'b0;
         phase         <= 1'b0;
         div_cnt       <= '0;
         bit_cnt       <= '0;
         grd_cnt       <= '0;
         s_axis_tready <= 1'b0;
         alex_flag     <= 1'b0;
         alex_data     <= '0;
         busy          <= 1'b0;
      end else begin
         state         <= state_nxt;
         shreg         <= shreg_nxt;
         sel           <= sel_nxt;
         phase         <= phase_nxt;
         div_cnt       <= div_nxt;
         bit_cnt       <= bit_nxt;
         grd_cnt       <= grd_nxt;
         s_axis_tready <= tready_nxt;
         alex_flag     <= flag_nxt;
         alex_data     <= data_nxt;
         busy          <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_axis_alex_ctrl.sv
// Directed bench for axis_alex_ctrl: default-parameter instance plus a
// CLK_DIV=1/GUARD=1 instance, observed through a shared pin monitor.
module tb_axis_alex_ctrl;

   logic        aclk = 1'b0;
   logic        areset;
   logic        enable;
   logic        s_tvalid;
   logic [31:0] s_tdata;
   logic        mon_b;

   logic        tready_a, flag_a, busy_a;
   logic [3:0]  data_a;
   logic        tready_b, flag_b, busy_b;
   logic [3:0]  data_b;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   always #5 aclk = ~aclk;

   axis_alex_ctrl dut_a (
      .aclk          (aclk),
      .areset        (areset),
      .enable        (enable),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid & ~mon_b),
      .s_axis_tready (tready_a),
      .alex_flag     (flag_a),
      .alex_data     (data_a),
      .busy          (busy_a)
   );

   axis_alex_ctrl #(.CLK_DIV(1), .GUARD(1)) dut_b (
      .aclk          (aclk),
      .areset        (areset),
      .enable        (enable),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid & mon_b),
      .s_axis_tready (tready_b),
      .alex_flag     (flag_b),
      .alex_data     (data_b),
      .busy          (busy_b)
   );

   wire       m_tready = mon_b ? tready_b : tready_a;
   wire       m_flag   = mon_b ? flag_b   : flag_a;
   wire       m_busy   = mon_b ? busy_b   : busy_a;
   wire [3:0] m_data   = mon_b ? data_b   : data_a;

   // Pin monitor: cumulative observations, sampled on the falling edge
   int          n_rise = 0, n_sclk_hi = 0, n_tx = 0, n_rx = 0, n_flag = 0;
   int          n_unstable = 0, hi_len = 0, lo_len = 0, first_rise = 0;
   logic [63:0] bits = '0;
   logic        p_sclk = 1'b0, p_sdata = 1'b0, p_flag = 1'b0;
   logic        seen = 1'b0, rise_seen = 1'b0;
   int          hi_runs[$];
   int          gaps[$];

   always @(negedge aclk) begin
      p_sclk  <= m_data[0];
      p_sdata <= m_data[1];
      p_flag  <= m_flag;
      if (m_data[0]) n_sclk_hi <= n_sclk_hi + 1;
      if (m_data[0] && !p_sclk) begin
         n_rise <= n_rise + 1;
         bits   <= {bits[62:0], m_data[1]};
         if (m_data[1] !== p_sdata) n_unstable <= n_unstable + 1;
         if (!rise_seen) begin
            first_rise <= hi_len + 1;
            rise_seen  <= 1'b1;
         end
      end
      if (m_data[0] && p_sclk && (m_data[1] !== p_sdata)) n_unstable <= n_unstable + 1;
      if (m_data[2]) n_tx <= n_tx + 1;
      if (m_data[3]) n_rx <= n_rx + 1;
      if (m_flag) begin
         n_flag <= n_flag + 1;
         if (!p_flag) begin
            if (seen) gaps.push_back(lo_len);
            hi_len    <= 1;
            rise_seen <= 1'b0;
         end else begin
            hi_len <= hi_len + 1;
         end
      end else begin
         if (p_flag) begin
            hi_runs.push_back(hi_len);
            seen   <= 1'b1;
            lo_len <= 1;
         end else begin
            lo_len <= lo_len + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Offer a word; returns on the falling edge after the accepting edge
   task automatic send(input logic [31:0] d, input bit keep, output int ok);
      logic hs;
      s_tdata  = d;
      s_tvalid = 1'b1;
      ok       = 0;
      for (int i = 0; i < 2000; i++) begin
         hs = m_tready;
         @(negedge aclk);
         if (hs) begin
            ok = 1;
            break;
         end
      end
      if (!keep) s_tvalid = 1'b0;
   endtask

   task automatic wait_tready(output int cnt);
      cnt = 1;
      while (!m_tready && cnt < 400) begin
         @(negedge aclk);
         cnt++;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 500 && m_busy; i++) @(negedge aclk);
      repeat (2) @(negedge aclk);
   endtask

   initial begin
      int ok, cnt, r0, sh0, tx0, rx0, f0, nr0, ng0, trc;

      areset = 1'b1; enable = 1'b0; s_tvalid = 1'b0; s_tdata = '0; mon_b = 1'b0;
      repeat (3) @(negedge aclk);
      check("rst_tready", 32'(tready_a), 32'd0);
      check("rst_flag",   32'(flag_a),   32'd0);
      check("rst_data",   32'(data_a),   32'd0);
      check("rst_busy",   32'(busy_a),   32'd0);
      check("rst_flag_b", 32'(flag_b),   32'd0);
      areset = 1'b0; enable = 1'b1;
      repeat (2) @(negedge aclk);

      // Single TX word with default timing
      r0 = n_rise; sh0 = n_sclk_hi; tx0 = n_tx; rx0 = n_rx;
      send(32'h0000_A5C3, 1'b0, ok);
      check("t1_hs", 32'(ok), 32'd1);
      wait_tready(cnt);
      check("t1_tready_lat", 32'(cnt), 32'd137);
      repeat (2) @(negedge aclk);
      check("t1_bits",      32'(bits[15:0]), 32'h0000_A5C3);
      check("t1_rises",     32'(n_rise - r0), 32'd16);
      check("t1_sclk_hi",   32'(n_sclk_hi - sh0), 32'd64);
      check("t1_tx_len",    32'(n_tx - tx0), 32'd4);
      check("t1_rx_len",    32'(n_rx - rx0), 32'd0);
      check("t1_flag_len",  32'(hi_runs[$]), 32'd136);
      check("t1_first_rise", 32'(first_rise), 32'd7);

      // RX-strobe word, all ones
      r0 = n_rise; tx0 = n_tx; rx0 = n_rx;
      send(32'h0001_FFFF, 1'b0, ok);
      check("t2_hs", 32'(ok), 32'd1);
      wait_idle();
      check("t2_bits",     32'(bits[15:0]), 32'h0000_FFFF);
      check("t2_rises",    32'(n_rise - r0), 32'd16);
      check("t2_tx_len",   32'(n_tx - tx0), 32'd0);
      check("t2_rx_len",   32'(n_rx - rx0), 32'd4);

      // Back-to-back with tvalid held high
      r0 = n_rise; tx0 = n_tx; rx0 = n_rx; nr0 = hi_runs.size(); ng0 = gaps.size();
      send(32'h0000_0000, 1'b1, ok);
      check("t3_hs0", 32'(ok), 32'd1);
      send(32'h0000_8001, 1'b1, ok);
      check("t3_hs1", 32'(ok), 32'd1);
      send(32'h0001_FFFF, 1'b0, ok);
      check("t3_hs2", 32'(ok), 32'd1);
      wait_idle();
      check("t3_runs",    32'(hi_runs.size() - nr0), 32'd3);
      check("t3_gaps",    32'(gaps.size() - ng0), 32'd3);
      check("t3_len2",    32'(hi_runs[$]), 32'd136);
      check("t3_len1",    32'(hi_runs[$-1]), 32'd136);
      check("t3_len0",    32'(hi_runs[$-2]), 32'd136);
      check("t3_gap1",    32'(gaps[$]), 32'd1);
      check("t3_gap0",    32'(gaps[$-1]), 32'd1);
      check("t3_rises",   32'(n_rise - r0), 32'd48);
      check("t3_bits_hi", bits[47:16], 32'h0000_8001);
      check("t3_bits_lo", 32'(bits[15:0]), 32'h0000_FFFF);
      check("t3_tx_len",  32'(n_tx - tx0), 32'd8);
      check("t3_rx_len",  32'(n_rx - rx0), 32'd4);

      // enable low blocks acceptance
      enable = 1'b0;
      repeat (2) @(negedge aclk);
      f0 = n_flag; trc = 0;
      s_tdata = 32'h0000_1234; s_tvalid = 1'b1;
      repeat (100) begin
         @(negedge aclk);
         if (m_tready) trc++;
      end
      s_tvalid = 1'b0;
      @(negedge aclk);
      check("t4_tready", 32'(trc), 32'd0);
      check("t4_flag",   32'(n_flag - f0), 32'd0);

      // enable dropped mid-SHIFT: transfer completes, then no acceptance
      enable = 1'b1;
      repeat (2) @(negedge aclk);
      r0 = n_rise;
      send(32'h0000_3C5A, 1'b0, ok);
      check("t5_hs", 32'(ok), 32'd1);
      repeat (40) @(negedge aclk);
      enable = 1'b0;
      s_tdata = 32'h0000_FFFF; s_tvalid = 1'b1;
      wait_idle();
      f0 = n_flag; trc = 0;
      repeat (20) begin
         @(negedge aclk);
         if (m_tready) trc++;
      end
      s_tvalid = 1'b0;
      @(negedge aclk);
      check("t5_bits",     32'(bits[15:0]), 32'h0000_3C5A);
      check("t5_rises",    32'(n_rise - r0), 32'd16);
      check("t5_flag_len", 32'(hi_runs[$]), 32'd136);
      check("t5_tready",   32'(trc), 32'd0);
      check("t5_no_flag",  32'(n_flag - f0), 32'd0);

      // Reset pulse mid-SHIFT, then a clean word
      enable = 1'b1;
      repeat (2) @(negedge aclk);
      send(32'h0000_A5C3, 1'b0, ok);
      check("t6_hs", 32'(ok), 32'd1);
      repeat (30) @(negedge aclk);
      areset = 1'b1;
      @(negedge aclk);
      check("t6_tready", 32'(tready_a), 32'd0);
      check("t6_flag",   32'(flag_a),   32'd0);
      check("t6_data",   32'(data_a),   32'd0);
      check("t6_busy",   32'(busy_a),   32'd0);
      areset = 1'b0;
      repeat (2) @(negedge aclk);
      r0 = n_rise;
      send(32'h0000_3C96, 1'b0, ok);
      check("t6_hs2", 32'(ok), 32'd1);
      wait_idle();
      check("t6_bits",       32'(bits[15:0]), 32'h0000_3C96);
      check("t6_rises",      32'(n_rise - r0), 32'd16);
      check("t6_flag_len",   32'(hi_runs[$]), 32'd136);
      check("t6_first_rise", 32'(first_rise), 32'd7);

      // CLK_DIV=1, GUARD=1 instance
      mon_b = 1'b1;
      repeat (2) @(negedge aclk);
      r0 = n_rise; sh0 = n_sclk_hi; tx0 = n_tx; rx0 = n_rx;
      send(32'h0000_5555, 1'b0, ok);
      check("t7_hs", 32'(ok), 32'd1);
      wait_tready(cnt);
      check("t7_tready_lat", 32'(cnt), 32'd36);
      repeat (2) @(negedge aclk);
      check("t7_bits",       32'(bits[15:0]), 32'h0000_5555);
      check("t7_rises",      32'(n_rise - r0), 32'd16);
      check("t7_sclk_hi",    32'(n_sclk_hi - sh0), 32'd16);
      check("t7_flag_len",   32'(hi_runs[$]), 32'd35);
      check("t7_first_rise", 32'(first_rise), 32'd3);
      check("t7_tx_len",     32'(n_tx - tx0), 32'd1);
      check("t7_rx_len",     32'(n_rx - rx0), 32'd0);
      check("sdata_stable",  32'(n_unstable), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
